// File: rtl/regfile_write_arbiter.sv
// Write-port owner for the 32x32 register bank: sequences the post-reset
// default-value load, then round-robin arbitrates core writeback and I/O
// input writes onto a single registered write port.
module regfile_write_arbiter #(
  parameter int          DATA_W   = 32,
  parameter int          ADDR_W   = 5,
  parameter int unsigned INIT_R30 = 126,
  parameter int unsigned INIT_R31 = 127
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              core_valid,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_data,
  output logic              core_ready,
  input  logic              io_valid,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_data,
  output logic              io_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              init_done
);

  typedef enum logic {INIT, RUN} state_t;
  typedef enum logic {LG_CORE, LG_IO} grant_t;

  state_t            state, state_nxt;
  grant_t            last_grant;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] init_val;

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) state <= INIT;
    else          state <= state_nxt;
  end

  // Next state: INIT ends on the edge that writes the top register
  always_comb begin
    state_nxt = state;
    if (state == INIT && ptr == '1) state_nxt = RUN;
  end

  // Readies: only in RUN; on a tie the requester not granted last wins
  always_comb begin
    core_ready = 1'b0;
    io_ready   = 1'b0;
    if (state == RUN) begin
      core_ready = core_valid && (!io_valid || last_grant == LG_IO);
      io_ready   = io_valid && (!core_valid || last_grant == LG_CORE);
    end
  end

  // Default value for the register currently addressed by the init pointer
  always_comb begin
    init_val = '0;
    if (ptr == ADDR_W'(30))      init_val = DATA_W'(INIT_R30);
    else if (ptr == ADDR_W'(31)) init_val = DATA_W'(INIT_R31);
  end

  // Registered write port, init pointer, grant history and init_done
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ptr        <= ADDR_W'(1);
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      init_done  <= 1'b0;
      last_grant <= LG_IO;
    end else if (state == INIT) begin
      rf_we    <= 1'b1;
      rf_waddr <= ptr;
      rf_wdata <= init_val;
      ptr      <= ptr + ADDR_W'(1);
      if (ptr == '1) init_done <= 1'b1;
    end else if (core_ready) begin
      // r0 is hard-wired: the handshake completes but the write is dropped
      rf_we      <= (core_addr != '0);
      rf_waddr   <= core_addr;
      rf_wdata   <= core_data;
      last_grant <= LG_CORE;
    end else if (io_ready) begin
      rf_we      <= (io_addr != '0);
      rf_waddr   <= io_addr;
      rf_wdata   <= io_data;
      last_grant <= LG_IO;
    end else begin
      rf_we <= 1'b0;
    end
  end

endmodule
